// File: rtl/viterbi_obs_framer.sv
// Ping-pong frame buffer feeding viterbi_top: one bank fills from a valid/ready stream
// while the other is replayed to the decoder as a start pulse plus one symbol per cycle.
module viterbi_obs_framer #(
    parameter int unsigned N  = 8,
    parameter int unsigned K  = 3,
    parameter int unsigned SW = $clog2(K),
    parameter int unsigned LW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] s_obs,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic          dec_start,
    output logic [LW-1:0] dec_length,
    output logic [SW-1:0] dec_obs,
    output logic          dec_obs_valid,
    input  logic          dec_done,
    output logic          busy,
    output logic          frame_trunc
);

    localparam int unsigned Depth = N - 1;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StWaitDone
    } state_e;

    // Bank storage and per-bank bookkeeping
    logic [SW-1:0] r_mem [2][Depth];
    logic [1:0]    r_full;
    logic [LW-1:0] r_len [2];

    // Fill side
    logic          r_wr_bank;
    logic [LW-1:0] r_wr_cnt;
    logic          r_frame_trunc;

    // Player side
    state_e        r_state;
    logic          r_rd_bank;
    logic [LW-1:0] r_rd_cnt;
    logic          r_dec_start;
    logic [LW-1:0] r_dec_length;
    logic [SW-1:0] r_dec_obs;
    logic          r_dec_obs_valid;
    logic          r_busy;

    logic          w_wr_fire;
    logic          w_wr_close;
    logic [LW-1:0] w_wr_cnt_d;
    logic [1:0]    w_full_d;
    logic          w_release;
    logic          w_play_last;
    state_e        w_state_next;
    logic          w_start_d;
    logic          w_obs_valid_d;
    logic [SW-1:0] w_obs_d;
    logic [LW-1:0] w_length_d;
    logic [LW-1:0] w_rd_cnt_d;
    logic          w_busy_d;

    // Ready depends only on registered state so it never loops back through s_valid.
    assign s_ready    = !r_full[r_wr_bank];
    assign w_wr_fire  = s_valid && s_ready;
    assign w_wr_close = w_wr_fire && (s_last || (r_wr_cnt == LW'(N - 2)));

    always_comb begin
        w_wr_cnt_d = r_wr_cnt;
        if (w_wr_close) begin
            w_wr_cnt_d = '0;
        end else if (w_wr_fire) begin
            w_wr_cnt_d = r_wr_cnt + LW'(1);
        end
    end

    // Close and release always target different banks, so both may apply in one cycle.
    always_comb begin
        w_full_d = r_full;
        if (w_wr_close) begin
            w_full_d[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_d[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_cnt] <= s_obs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full        <= '0;
            r_len[0]      <= '0;
            r_len[1]      <= '0;
            r_wr_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_frame_trunc <= 1'b0;
        end else begin
            r_full        <= w_full_d;
            r_wr_cnt      <= w_wr_cnt_d;
            r_frame_trunc <= w_wr_close && !s_last;
            if (w_wr_close) begin
                r_len[r_wr_bank] <= r_wr_cnt + LW'(1);
                r_wr_bank        <= !r_wr_bank;
            end
        end
    end

    assign w_play_last = (r_rd_cnt == (r_dec_length - LW'(1)));

    // Player: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= StIdle;
            r_rd_bank       <= 1'b0;
            r_rd_cnt        <= '0;
            r_dec_start     <= 1'b0;
            r_dec_length    <= '0;
            r_dec_obs       <= '0;
            r_dec_obs_valid <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_rd_bank       <= r_rd_bank ^ w_release;
            r_rd_cnt        <= w_rd_cnt_d;
            r_dec_start     <= w_start_d;
            r_dec_length    <= w_length_d;
            r_dec_obs       <= w_obs_d;
            r_dec_obs_valid <= w_obs_valid_d;
            r_busy          <= w_busy_d;
        end
    end

    // Player: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next = StPlay;
                end
            end
            StPlay: begin
                if (w_play_last) begin
                    w_state_next = StWaitDone;
                end
            end
            StWaitDone: begin
                if (dec_done) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Player: outputs, registered one cycle ahead of the decoder
    always_comb begin
        w_start_d     = 1'b0;
        w_obs_valid_d = 1'b0;
        w_obs_d       = r_dec_obs;
        w_length_d    = r_dec_length;
        w_rd_cnt_d    = r_rd_cnt;
        w_release     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_full[r_rd_bank]) begin
                    w_start_d     = 1'b1;
                    w_obs_valid_d = 1'b1;
                    w_obs_d       = r_mem[r_rd_bank][0];
                    w_length_d    = r_len[r_rd_bank];
                    w_rd_cnt_d    = '0;
                end
            end
            StPlay: begin
                if (!w_play_last) begin
                    w_rd_cnt_d    = r_rd_cnt + LW'(1);
                    w_obs_valid_d = 1'b1;
                    w_obs_d       = r_mem[r_rd_bank][w_rd_cnt_d];
                end
            end
            StWaitDone: begin
                w_release = dec_done;
            end
            default: begin
                w_release = 1'b0;
            end
        endcase
    end

    assign w_busy_d = (|w_full_d) || (w_wr_cnt_d != '0) || (w_state_next != StIdle);

    assign dec_start     = r_dec_start;
    assign dec_length    = r_dec_length;
    assign dec_obs       = r_dec_obs;
    assign dec_obs_valid = r_dec_obs_valid;
    assign busy          = r_busy;
    assign frame_trunc   = r_frame_trunc;

endmodule
